// File: rtl/piano_pkg.sv
// Shared constants and types for the piano note scheduler.
//   NOTE_DIV   : per-semitone tone period-1 (index 0 = A)
//   state_e    : scheduler FSM encodings
//   note_div() : guarded table lookup (out-of-range notes map to entry 0)
package piano_pkg;

  localparam int unsigned NUM_KEYS   = 12;
  localparam int unsigned MAX_OCTAVE = 5;
  localparam int unsigned NOTE_W     = 4;
  localparam int unsigned OCT_W      = 3;
  localparam int unsigned DIV_W      = 9;

  localparam logic [DIV_W-1:0] NOTE_DIV [0:NUM_KEYS-1] = '{
    9'd511, 9'd482, 9'd455, 9'd430, 9'd405, 9'd383,
    9'd361, 9'd341, 9'd322, 9'd303, 9'd286, 9'd270
  };

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPlay    = 2'd1,
    StRelease = 2'd2
  } state_e;

  function automatic logic [DIV_W-1:0] note_div(input logic [NOTE_W-1:0] n);
    if (n < NOTE_W'(NUM_KEYS)) begin
      return NOTE_DIV[n];
    end
    return NOTE_DIV[0];
  endfunction

endpackage

// File: rtl/note_scheduler_key_select.sv
// Combinational find-next-set over the key vector.
//   vec   : held keys
//   start : first index examined when mode=1 (search wraps past the top key)
//   mode  : 0 = lowest set bit from index 0, 1 = round-robin from start
//   idx   : index of the bit found (0 when none)
//   found : 1 when any bit of vec is set
module note_scheduler_key_select
  import piano_pkg::*;
(
  input  logic [NUM_KEYS-1:0] vec,
  input  logic [NOTE_W-1:0]   start,
  input  logic                mode,
  output logic [NOTE_W-1:0]   idx,
  output logic                found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      automatic int pos = mode ? ((int'(start) + i) % int'(NUM_KEYS)) : i;
      if (!found && vec[pos]) begin
        idx   = NOTE_W'(pos);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Shares one tone generator between the piano keys: samples the key bank, picks the
// sounding key, and drives note/octave/clkdivider/gate into the tone datapath.
// Also tracks the octave selected by the up/down buttons.
// Build option: ARPEGGIO_EN selects round-robin arpeggio; undefined = lowest-key priority.
//   clk, rst          : clock, synchronous active-high reset
//   keys              : key levels (1 = pressed), already debounced
//   oct_up, oct_down  : single-cycle octave step pulses
//   note, octave      : selected semitone (0 = A) and current octave
//   clkdivider        : registered period-1 lookup of note
//   gate              : tone generator should sound
//   note_strobe       : one-cycle pulse when note or octave changes
module note_scheduler
  import piano_pkg::*;
#(
  parameter int unsigned N_KEYS         = 12,
  parameter int unsigned ARP_TICKS      = 4194304,
  parameter int unsigned RELEASE_CYCLES = 1048576,
  parameter int unsigned OCT_DEFAULT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys,
  input  logic              oct_up,
  input  logic              oct_down,
  output logic [NOTE_W-1:0] note,
  output logic [OCT_W-1:0]  octave,
  output logic [DIV_W-1:0]  clkdivider,
  output logic              gate,
  output logic              note_strobe
);

  localparam int unsigned RelW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  state_e              state_q;
  logic [NUM_KEYS-1:0] keys_q;
  logic [NOTE_W-1:0]   note_q;
  logic [OCT_W-1:0]    octave_q, oct_d;
  logic [DIV_W-1:0]    div_q;
  logic                gate_q, strobe_q;
  logic [RelW-1:0]     rel_cnt_q;
  logic                oct_chg;

  // Keys above index 11 are dropped; narrower banks are zero-extended.
  logic [NUM_KEYS-1:0] keys_ext;
  assign keys_ext = NUM_KEYS'(keys);

  logic [NOTE_W-1:0] low_idx;
  logic              any_key;

  note_scheduler_key_select u_prio (
    .vec   (keys_q),
    .start ('0),
    .mode  (1'b0),
    .idx   (low_idx),
    .found (any_key)
  );

`ifdef ARPEGGIO_EN
  localparam int unsigned StepW = (ARP_TICKS > 1) ? $clog2(ARP_TICKS) : 1;

  logic [StepW-1:0]  step_q;
  logic [NOTE_W-1:0] rr_start, rr_idx;
  logic              rr_found;

  assign rr_start = (note_q == NOTE_W'(NUM_KEYS - 1)) ? '0 : note_q + 1'b1;

  // Searching from note+1 with wrap reaches the current key last, so a lone held
  // key selects itself and produces no strobe.
  note_scheduler_key_select u_rr (
    .vec   (keys_q),
    .start (rr_start),
    .mode  (1'b1),
    .idx   (rr_idx),
    .found (rr_found)
  );
`endif

  always_comb begin
    oct_d = octave_q;
    if (oct_up && !oct_down && (octave_q != OCT_W'(MAX_OCTAVE))) begin
      oct_d = octave_q + 1'b1;
    end else if (oct_down && !oct_up && (octave_q != '0)) begin
      oct_d = octave_q - 1'b1;
    end
    oct_chg = (oct_d != octave_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      keys_q    <= '0;
      note_q    <= '0;
      octave_q  <= OCT_W'(OCT_DEFAULT);
      div_q     <= NOTE_DIV[0];
      gate_q    <= 1'b0;
      strobe_q  <= 1'b0;
      rel_cnt_q <= '0;
`ifdef ARPEGGIO_EN
      step_q    <= '0;
`endif
    end else begin
      keys_q   <= keys_ext;
      octave_q <= oct_d;
      strobe_q <= oct_chg;
      unique case (state_q)
        StIdle: begin
          gate_q <= 1'b0;
          if (any_key) begin
            state_q  <= StPlay;
            gate_q   <= 1'b1;
            note_q   <= low_idx;
            div_q    <= note_div(low_idx);
            strobe_q <= 1'b1;
`ifdef ARPEGGIO_EN
            step_q   <= '0;
`endif
          end
        end
        StPlay: begin
          gate_q <= 1'b1;
          if (!any_key) begin
            state_q   <= StRelease;
            rel_cnt_q <= RelW'(RELEASE_CYCLES - 1);
          end else begin
`ifdef ARPEGGIO_EN
            // Losing the current key steps at once; otherwise step on terminal count.
            if (!keys_q[note_q] || (step_q == StepW'(ARP_TICKS - 1))) begin
              step_q <= '0;
              if (rr_found && (rr_idx != note_q)) begin
                note_q   <= rr_idx;
                div_q    <= note_div(rr_idx);
                strobe_q <= 1'b1;
              end
            end else begin
              step_q <= step_q + 1'b1;
            end
`else
            if (low_idx != note_q) begin
              note_q   <= low_idx;
              div_q    <= note_div(low_idx);
              strobe_q <= 1'b1;
            end
`endif
          end
        end
        StRelease: begin
          if (any_key) begin
            state_q  <= StPlay;
            gate_q   <= 1'b1;
            note_q   <= low_idx;
            div_q    <= note_div(low_idx);
            strobe_q <= 1'b1;
`ifdef ARPEGGIO_EN
            step_q   <= '0;
`endif
          end else if (rel_cnt_q == '0) begin
            state_q <= StIdle;
            gate_q  <= 1'b0;
          end else begin
            gate_q    <= 1'b1;
            rel_cnt_q <= rel_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

  assign note        = note_q;
  assign octave      = octave_q;
  assign clkdivider  = div_q;
  assign gate        = gate_q;
  assign note_strobe = strobe_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler with small timing parameters
// (RELEASE_CYCLES=8, ARP_TICKS=4). Each vector drives one cycle of inputs and
// names the outputs expected just after the next rising edge.
module tb_note_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] keys;
  logic        oct_up, oct_down;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic [8:0]  clkdivider;
  logic        gate, note_strobe;

  always #5 clk = ~clk;

  note_scheduler #(
    .N_KEYS         (12),
    .ARP_TICKS      (4),
    .RELEASE_CYCLES (8),
    .OCT_DEFAULT    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keys        (keys),
    .oct_up      (oct_up),
    .oct_down    (oct_down),
    .note        (note),
    .octave      (octave),
    .clkdivider  (clkdivider),
    .gate        (gate),
    .note_strobe (note_strobe)
  );

  typedef struct {
    logic        rst;
    logic [11:0] keys;
    logic        up;
    logic        down;
    int unsigned note;
    int unsigned oct;
    int unsigned gate;
    int unsigned strb;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   row      = 0;

  function automatic int unsigned exp_div(input int unsigned n);
    case (n)
      0: return 511;   1: return 482;   2: return 455;   3: return 430;
      4: return 405;   5: return 383;   6: return 361;   7: return 341;
      8: return 322;   9: return 303;   10: return 286;  11: return 270;
      default: return 511;
    endcase
  endfunction

  task automatic add(input logic r, input logic [11:0] k, input logic u, input logic d,
                     input int unsigned n, input int unsigned o, input int unsigned g,
                     input int unsigned s);
    vec_t v;
    v.rst = r; v.keys = k; v.up = u; v.down = d;
    v.note = n; v.oct = o; v.gate = g; v.strb = s;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, want);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    rst = v.rst; keys = v.keys; oct_up = v.up; oct_down = v.down;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("note", 32'(note), e.note);
      chk("octave", 32'(octave), e.oct);
      chk("clkdivider", 32'(clkdivider), exp_div(e.note));
      chk("gate", 32'(gate), e.gate);
      chk("note_strobe", 32'(note_strobe), e.strb);
    end
    row++;
  endtask

  initial begin
    rst = 1'b1; keys = '0; oct_up = 1'b0; oct_down = 1'b0;

    // Reset, then a single key: two-cycle latency and one strobe.
    add(1, 12'h000, 0, 0, 0, 2, 0, 0);
    add(0, 12'h001, 0, 0, 0, 2, 0, 0);
    add(0, 12'h001, 0, 0, 0, 2, 1, 1);
    add(0, 12'h001, 0, 0, 0, 2, 1, 0);
    // Release: gate stays high for 8 cycles after the FSM sees no keys.
    add(0, 12'h000, 0, 0, 0, 2, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 12'h000, 0, 0, 0, 2, 1, 0);
    add(0, 12'h000, 0, 0, 0, 2, 0, 0);
    add(0, 12'h000, 0, 0, 0, 2, 0, 0);
    // Two keys, drop the lower, then re-press inside the release window.
    add(0, 12'h090, 0, 0, 0, 2, 0, 0);
    add(0, 12'h090, 0, 0, 4, 2, 1, 1);
    add(0, 12'h080, 0, 0, 4, 2, 1, 0);
    add(0, 12'h080, 0, 0, 7, 2, 1, 1);
    add(0, 12'h080, 0, 0, 7, 2, 1, 0);
    add(0, 12'h000, 0, 0, 7, 2, 1, 0);
    add(0, 12'h000, 0, 0, 7, 2, 1, 0);
    add(0, 12'h000, 0, 0, 7, 2, 1, 0);
    add(0, 12'h004, 0, 0, 7, 2, 1, 0);
    add(0, 12'h004, 0, 0, 2, 2, 1, 1);
    add(0, 12'h004, 0, 0, 2, 2, 1, 0);
    // Octave saturation at both ends and simultaneous up/down.
    add(0, 12'h004, 1, 0, 2, 3, 1, 1);
    add(0, 12'h004, 1, 0, 2, 4, 1, 1);
    add(0, 12'h004, 1, 0, 2, 5, 1, 1);
    add(0, 12'h004, 1, 0, 2, 5, 1, 0);
    add(0, 12'h004, 1, 0, 2, 5, 1, 0);
    add(0, 12'h004, 1, 1, 2, 5, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 12'h004, 0, 1, 2, 32'(4 - i), 1, 1);
    add(0, 12'h004, 0, 1, 2, 0, 1, 0);
    add(0, 12'h004, 1, 0, 2, 1, 1, 1);
    // Note and octave change in the same cycle: one strobe.
    add(0, 12'h010, 0, 0, 2, 1, 1, 0);
    add(0, 12'h010, 0, 1, 4, 0, 1, 1);
    add(0, 12'h010, 0, 0, 4, 0, 1, 0);
    // Reset mid-note.
    add(1, 12'h010, 0, 0, 0, 2, 0, 0);
    add(0, 12'h000, 0, 0, 0, 2, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

`ifdef ARPEGGIO_EN
    // Round-robin over keys 2,5,11 every 4 cycles, then release the current key 5.
    vecs.delete();
    add(0, 12'h824, 0, 0, 0, 2, 0, 0);
    add(0, 12'h824, 0, 0, 2, 2, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 12'h824, 0, 0, 2, 2, 1, 0);
    add(0, 12'h824, 0, 0, 5, 2, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 12'h824, 0, 0, 5, 2, 1, 0);
    add(0, 12'h824, 0, 0, 11, 2, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 12'h824, 0, 0, 11, 2, 1, 0);
    add(0, 12'h824, 0, 0, 2, 2, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 12'h824, 0, 0, 2, 2, 1, 0);
    add(0, 12'h824, 0, 0, 5, 2, 1, 1);
    add(0, 12'h804, 0, 0, 5, 2, 1, 0);
    add(0, 12'h804, 0, 0, 11, 2, 1, 1);
    add(0, 12'h804, 0, 0, 11, 2, 1, 0);
    foreach (vecs[i]) apply(vecs[i]);
`else
    // A lower key pressed later takes over immediately, and hands back when released.
    vecs.delete();
    add(0, 12'h090, 0, 0, 0, 2, 0, 0);
    add(0, 12'h090, 0, 0, 4, 2, 1, 1);
    add(0, 12'h092, 0, 0, 4, 2, 1, 0);
    add(0, 12'h092, 0, 0, 1, 2, 1, 1);
    add(0, 12'h090, 0, 0, 1, 2, 1, 0);
    add(0, 12'h090, 0, 0, 4, 2, 1, 1);
    add(0, 12'h090, 0, 0, 4, 2, 1, 0);
    foreach (vecs[i]) apply(vecs[i]);
`endif

    if (exp_q.size() != 0) chk("scoreboard_leftover", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
